// File: rtl/add_mul_mix_arb.sv
// add_mul_mix_arb: two-requester round-robin arbiter feeding one shared adder pair and shift-add multiplier
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN_valid/ready/ops  : requester N operation handshake, ops = {a, b, c, d} (4 bits each)
//   res_valid/ready       : result handshake
//   res_data, res_id      : ((a+b) mod 16) * ((c+d) mod 16) and the issuing requester
module add_mul_mix_arb #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_ops,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_ops,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_id
);
    typedef enum logic [1:0] {IDLE, ADD, MUL, DONE} state_e;
    state_e      state_q, state_d;
    logic        ptr_q, id_q, res_id_q;
    logic [15:0] ops_q;
    logic [3:0]  s1_q, s2_q;
    logic [7:0]  acc_q, acc_d, res_data_q;
    logic [1:0]  cnt_q;
    logic        any_v, gnt_id;
    // Pointer only breaks ties; a lone valid requester always wins.
    assign any_v  = req0_valid | req1_valid;
    assign gnt_id = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    assign acc_d  = acc_q + (s2_q[cnt_q] ? ({4'b0, s1_q} << cnt_q) : 8'd0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_v ? ADD : IDLE;
            ADD:     state_d = MUL;
            MUL:     state_d = (cnt_q == 2'd3) ? DONE : MUL;
            DONE:    state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // Readies are gated by rst_n so they are low for the whole reset pulse, not just after the edge.
    always_comb begin
        req0_ready = rst_n & (state_q == IDLE) & any_v & ~gnt_id;
        req1_ready = rst_n & (state_q == IDLE) & any_v & gnt_id;
        res_valid  = (state_q == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= RR_INIT;
            id_q       <= 1'b0;
            ops_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && any_v) begin
                ops_q <= gnt_id ? req1_ops : req0_ops;
                id_q  <= gnt_id;
                ptr_q <= ~gnt_id;
            end
            if (state_q == ADD) begin
                s1_q  <= ops_q[15:12] + ops_q[11:8];
                s2_q  <= ops_q[7:4] + ops_q[3:0];
                acc_q <= '0;
                cnt_q <= '0;
            end
            // Result registers load only on the final multiply step so they hold outside DONE.
            if (state_q == MUL) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    res_data_q <= acc_d;
                    res_id_q   <= id_q;
                end
            end
        end
    end
    assign res_data = res_data_q;
    assign res_id   = res_id_q;
endmodule

// File: tb/tb_add_mul_mix_arb.sv
// tb_add_mul_mix_arb: randomized self-checking bench for add_mul_mix_arb against an arithmetic model
module tb_add_mul_mix_arb;
    localparam logic RR_INIT = 1'b0;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic        req0_ready, req1_ready, res_valid, res_id;
    logic [15:0] req0_ops = '0, req1_ops = '0;
    logic [7:0]  res_data;
    logic        ptr_m;
    int          checks = 0, errors = 0;

    add_mul_mix_arb #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ops(req0_ops),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ops(req1_ops),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [15:0] o);
        int s1, s2;
        s1 = (int'(o[15:12]) + int'(o[11:8])) % 16;
        s2 = (int'(o[7:4]) + int'(o[3:0])) % 16;
        return 8'(s1 * s2);
    endfunction

    // Starts in an IDLE cycle (just after a rising edge); returns in the IDLE cycle after release.
    task automatic run_op(input logic v0, input logic v1, input logic [15:0] o0, input logic [15:0] o1, input int stall);
        logic       g;
        logic [7:0] exp;
        g   = (v0 && v1) ? ptr_m : v1;
        exp = model(g ? o1 : o0);
        req0_valid = v0; req1_valid = v1; req0_ops = o0; req1_ops = o1; res_ready = (stall == 0);
        @(negedge clk);
        checks++;
        if ({res_valid, req1_ready, req0_ready} !== {1'b0, g, ~g}) begin
            errors++;
            $display("FAIL grant: valid,ready1,ready0=%b expected %b", {res_valid, req1_ready, req0_ready}, {1'b0, g, ~g});
        end
        ptr_m = ~g;
        @(posedge clk); #1;
        req0_ops = 16'($urandom); req1_ops = 16'($urandom);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, req0_ready, req1_ready} !== 3'b000) begin
                errors++;
                $display("FAIL busy cycle %0d: valid,ready0,ready1=%b expected 000", k, {res_valid, req0_ready, req1_ready});
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k <= stall; k++) begin
            if (k == stall) res_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({res_valid, res_id, res_data, req0_ready, req1_ready} !== {1'b1, g, exp, 2'b00}) begin
                errors++;
                $display("FAIL result stall %0d: valid=%b id=%b data=%0d rdy=%b%b expected valid=1 id=%b data=%0d rdy=00",
                         k, res_valid, res_id, res_data, req0_ready, req1_ready, g, exp);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_data, req0_ready, req1_ready} !== 12'h000) begin
            errors++;
            $display("FAIL reset outputs: valid=%b id=%b data=%0d rdy=%b%b expected all zero",
                     res_valid, res_id, res_data, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = RR_INIT;
    endtask

    task automatic test_directed;
        run_op(1'b1, 1'b0, 16'h3456, 16'h0000, 0);
        run_op(1'b0, 1'b1, 16'h0000, 16'hFF99, 0);
        run_op(1'b1, 1'b0, 16'h78F0, 16'h0000, 1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run_op(v[0], v[1], 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_rr;
        test_reset;
        for (int n = 0; n < 4; n++) run_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0);
    endtask

    task automatic test_stall;
        run_op(1'b0, 1'b1, 16'h1234, 16'hA5C3, 3);
        run_op(1'b1, 1'b1, 16'hFFFF, 16'h0101, 3);
    endtask

    task automatic test_reset_mid;
        test_reset;
        req0_valid = 1'b1; req1_valid = 1'b0; req0_ops = 16'h2357;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({res_valid, req0_ready, req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL mid reset: valid,ready0,ready1=%b expected 000", {res_valid, req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        ptr_m = RR_INIT;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_data} !== 9'h000) begin
                errors++;
                $display("FAIL no result after reset cycle %0d: valid=%b data=%0d expected 0/0", k, res_valid, res_data);
            end
            @(posedge clk); #1;
        end
        run_op(1'b1, 1'b1, 16'h9876, 16'h4444, 0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_rr;
        test_stall;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
